// File: rtl/cache_maint_arbiter.sv
// cache_maint_arbiter: round-robin arbiter that serialises per-core cache
// maintenance requests (barrier, I-flush, D-flush) onto one downstream port.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_i[NUM_REQ]     per-requester level request, held until its done_o
//   type_i[2*NUM_REQ]  packed op per requester: 00 bar, 01 I-flush, 10 D-flush, 11 rsvd
//   done_o, err_o      one-cycle completion / error pulses (err only for op 11)
//   maint_req_o        downstream request level
//   maint_type_o       downstream op, latched at grant
//   maint_ack_i        downstream completion pulse (honoured only in S_BUSY)
//   grant_id_o         index of the current winner
//   busy_o             high whenever the FSM is not idle
//
// Optional feature macro: CACHE_MAINT_COALESCE_EN
//   When defined, requesters with the same op as the winner share its
//   downstream transaction (reserved op 11 is never coalesced).
module cache_maint_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NUM_REQ-1:0]   req_i,
   input  logic [2*NUM_REQ-1:0] type_i,
   output logic [NUM_REQ-1:0]   done_o,
   output logic [NUM_REQ-1:0]   err_o,
   output logic                 maint_req_o,
   output logic [1:0]           maint_type_o,
   input  logic                 maint_ack_i,
   output logic [ID_W-1:0]      grant_id_o,
   output logic                 busy_o
);

   localparam logic [1:0] OP_RSVD = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]   mask_q, mask_d;
   logic [1:0]           type_d;
   logic [ID_W-1:0]      gid_d;

   logic                 hi_found, lo_found;
   logic [ID_W-1:0]      hi_id, lo_id, win_id;
   logic [1:0]           win_type;
   logic [NUM_REQ-1:0]   win_mask;

   // Cyclic search from rr_ptr: lowest set bit at/above the pointer, else lowest overall.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_id    = '0;
      lo_id    = '0;
      for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
         if (req_i[j]) begin
            lo_found = 1'b1;
            lo_id    = ID_W'(j);
            if (j >= int'(rr_ptr_q)) begin
               hi_found = 1'b1;
               hi_id    = ID_W'(j);
            end
         end
      end
      win_id = hi_found ? hi_id : lo_id;
   end

   // Winner op and the set of requesters served by this grant.
   always_comb begin
      win_type = 2'b00;
      win_mask = '0;
      for (int j = 0; j < int'(NUM_REQ); j++) begin
         if (ID_W'(j) == win_id) begin
            win_type = type_i[2*j +: 2];
         end
      end
      for (int j = 0; j < int'(NUM_REQ); j++) begin
`ifdef CACHE_MAINT_COALESCE_EN
         win_mask[j] = (ID_W'(j) == win_id) ||
                       (req_i[j] && (type_i[2*j +: 2] == win_type) && (win_type != OP_RSVD));
`else
         win_mask[j] = (ID_W'(j) == win_id);
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      mask_d   = mask_q;
      type_d   = maint_type_o;
      gid_d    = grant_id_o;
      unique case (state_q)
         S_IDLE: begin
            if (lo_found) begin
               gid_d   = win_id;
               type_d  = win_type;
               mask_d  = win_mask;
               state_d = (win_type == OP_RSVD) ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            if (maint_ack_i) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            rr_ptr_d = (grant_id_o == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_o + ID_W'(1);
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered output decodes of the next state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         mask_q       <= '0;
         maint_type_o <= 2'b00;
         grant_id_o   <= '0;
         maint_req_o  <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= '0;
         err_o        <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         mask_q       <= mask_d;
         maint_type_o <= type_d;
         grant_id_o   <= gid_d;
         maint_req_o  <= (state_d == S_BUSY);
         busy_o       <= (state_d != S_IDLE);
         done_o       <= (state_d == S_DONE) ? mask_d : '0;
         err_o        <= ((state_d == S_DONE) && (type_d == OP_RSVD)) ? mask_d : '0;
      end
   end

endmodule
